// File: rtl/vec_cache_rd_req_xbar_nxm.sv
// Read-request crossbar: N command inputs to M cache banks.
// Each bank has a round-robin arbiter feeding a small registered FIFO.

package vec_cache_pkg;
    typedef enum logic [1:0] {
        VEC_CACHE_CMD_NOP   = 2'd0,
        VEC_CACHE_CMD_READ  = 2'd1,
        VEC_CACHE_CMD_WRITE = 2'd2
    } vec_cache_cmd_e;

    typedef struct packed {
        logic [63:0] cmd_addr;
        logic [7:0]  cmd_txnid;
        logic [7:0]  cmd_sideband;
    } input_read_cmd_pld_t;

    typedef struct packed {
        vec_cache_cmd_e cmd_opcode;
        logic [63:0]    cmd_addr;
        logic [7:0]     cmd_txnid;
        logic [7:0]     cmd_sideband;
        logic [7:0]     cmd_strb;
        logic [5:0]     db_entry_id;
        logic [5:0]     rob_entry_id;
    } input_req_pld_t;
endpackage

// One bank: RR arbiter over its requesters plus the output FIFO.
module vec_cache_rd_req_bank
    import vec_cache_pkg::*;
#(
    parameter int R     = 8,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [R-1:0]                req,
    input  input_req_pld_t [R-1:0]      pld,
    output logic [R-1:0]                acc,
    output logic                        vld,
    output input_req_pld_t              head,
    input  logic                        rdy,
    output logic [$clog2(DEPTH):0]      cnt
);
    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IW-1:0]  rr, win;
    logic           any, full, push, pop;
    logic [AW-1:0]  wptr, rptr;
    input_req_pld_t mem [DEPTH];
    int             idx;

    // Round-robin pick: first requester at or after rr, wrapping modulo R.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(rr) + k) % R;
            if (!any && req[idx]) begin
                any = 1'b1;
                win = IW'(idx);
            end
        end
    end

    // Full is judged on registered occupancy only, so a same-cycle pop never frees a slot.
    always_comb begin
        full = (cnt == CW'(DEPTH));
        push = any && !full;
        pop  = vld && rdy;
        acc  = '0;
        if (push) acc[win] = 1'b1;
    end

    assign vld  = (cnt != '0);
    assign head = mem[rptr];

    // Pointer, occupancy and arbiter state; rr only advances on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr   <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                rr   <= (win == IW'(R-1)) ? '0 : win + 1'b1;
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= pld[win];
    end
endmodule

module vec_cache_rd_req_xbar_nxm
    import vec_cache_pkg::*;
#(
    parameter int R_REQ_NUM = 8,
    parameter int BANK_NUM  = 4,
    parameter int SEL_LSB   = 62,
    parameter int OQ_DEPTH  = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [R_REQ_NUM-1:0]                      rd_cmd_vld,
    input  input_read_cmd_pld_t [R_REQ_NUM-1:0]       rd_cmd_pld,
    output logic [R_REQ_NUM-1:0]                      rd_cmd_rdy,
    output logic [BANK_NUM-1:0]                       sel_rd_vld,
    output input_req_pld_t [BANK_NUM-1:0]             sel_rd_pld,
    input  logic [BANK_NUM-1:0]                       sel_rd_rdy,
    output logic [BANK_NUM-1:0][$clog2(OQ_DEPTH):0]   bank_oq_cnt
);
    localparam int SEL_W = $clog2(BANK_NUM);

    logic [R_REQ_NUM-1:0][SEL_W-1:0]     sel;
    input_req_pld_t [R_REQ_NUM-1:0]      conv;
    logic [BANK_NUM-1:0][R_REQ_NUM-1:0]  req, acc;

    // Decode bank select and build the bank-side payload for every input.
    always_comb begin
        for (int i = 0; i < R_REQ_NUM; i++) begin
            sel[i]                  = rd_cmd_pld[i].cmd_addr[SEL_LSB +: SEL_W];
            conv[i].cmd_opcode      = VEC_CACHE_CMD_READ;
            conv[i].cmd_addr        = rd_cmd_pld[i].cmd_addr;
            conv[i].cmd_txnid       = rd_cmd_pld[i].cmd_txnid;
            conv[i].cmd_sideband    = rd_cmd_pld[i].cmd_sideband;
            conv[i].cmd_strb        = '0;
            conv[i].db_entry_id     = '0;
            conv[i].rob_entry_id    = '0;
        end
    end

    // Per-bank request vectors.
    always_comb begin
        for (int b = 0; b < BANK_NUM; b++)
            for (int i = 0; i < R_REQ_NUM; i++)
                req[b][i] = rd_cmd_vld[i] && (sel[i] == SEL_W'(b));
    end

    // Ready comes back from the selected bank only; held low while in reset.
    always_comb begin
        for (int i = 0; i < R_REQ_NUM; i++)
            rd_cmd_rdy[i] = rst_n && acc[sel[i]][i];
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        vec_cache_rd_req_bank #(.R(R_REQ_NUM), .DEPTH(OQ_DEPTH)) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req[b]),
            .pld   (conv),
            .acc   (acc[b]),
            .vld   (sel_rd_vld[b]),
            .head  (sel_rd_pld[b]),
            .rdy   (sel_rd_rdy[b]),
            .cnt   (bank_oq_cnt[b])
        );
    end
endmodule

// File: doc/vec_cache_rd_req_xbar_nxm.md
Name: vec_cache_rd_req_xbar_nxm

Overview:
- Parametrised N-input to M-bank read-request crossbar for the vector cache front end.
- Sits between the read command ports and the per-bank request pipelines. Converts each input_read_cmd_pld_t into an input_req_pld_t and routes it to the bank selected by configurable address bits.
- Each bank has its own round-robin arbiter and a registered output FIFO, so output timing is decoupled and bank backpressure does not reach the inputs combinationally.

Parameters:
- R_REQ_NUM, 8, number of read command inputs (>=2).
- BANK_NUM, 4, number of output banks; power of two, 2..16.
- SEL_LSB, 62, LSB of the bank-select field in cmd_addr. Field width SEL_W = log2(BANK_NUM). SEL_LSB+SEL_W must be <= 64.
- OQ_DEPTH, 2, per-bank output FIFO depth; power of two, >=2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- rd_cmd_vld  input  R_REQ_NUM  per-input command valid
- rd_cmd_pld  input  input_read_cmd_pld_t[R_REQ_NUM]  per-input command payload
- rd_cmd_rdy  output  R_REQ_NUM  per-input ready
- sel_rd_vld  output  BANK_NUM  per-bank request valid
- sel_rd_pld  output  input_req_pld_t[BANK_NUM]  per-bank request payload
- sel_rd_rdy  input  BANK_NUM  per-bank ready
- bank_oq_cnt  output  BANK_NUM*($clog2(OQ_DEPTH)+1)  per-bank FIFO occupancy, for debug and perf

Behaviour:
- Single clock domain; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - All FIFOs empty; sel_rd_vld=0; bank_oq_cnt=0.
  - All RR pointers =0.
  - rd_cmd_rdy=0 while rst_n is low.
- Bank select: sel[i] = rd_cmd_pld[i].cmd_addr[SEL_LSB +: SEL_W].
- Payload conversion:
  - addr, txnid and sideband are copied unchanged.
  - cmd_opcode = VEC_CACHE_CMD_READ.
  - strb, db_entry_id and rob_entry_id are forced to 0.
- Per bank b, request vector req_b[i] = rd_cmd_vld[i] && sel[i]==b.
- Arbitration:
  - Round-robin with a start pointer rr_b. Priority is rr_b, rr_b+1, … wrapping modulo R_REQ_NUM.
  - Exactly one grant per bank per cycle, and only when req_b is non-zero.
- rd_cmd_rdy[i] = grant to i from bank sel[i] AND that bank's FIFO is not full.
  - rd_cmd_rdy depends only on registered FIFO state and the inputs. It never depends combinationally on sel_rd_rdy.
  - A non-granted input sees rdy=0 and must hold vld and pld stable (valid/ready rule: no retraction).
- Push: happens on rd_cmd_vld[i] && rd_cmd_rdy[i]. The converted payload is written to the FIFO tail.
- Pointer update: rr_b <= winner+1 (mod R_REQ_NUM) only on an accepted push. With no push, rr_b holds.
- Output side:
  - sel_rd_vld[b] = FIFO not empty; sel_rd_pld[b] = FIFO head.
  - Pop on sel_rd_vld[b] && sel_rd_rdy[b].
  - Head payload is stable while vld && !rdy.
- Latency: an accepted input appears on sel_rd_vld at the next edge (1 cycle), if its bank FIFO was empty.
- Throughput: with OQ_DEPTH>=2 and sel_rd_rdy held high, 1 request per bank per cycle.
- Full FIFO: no push is accepted, even if a pop occurs in the same cycle. Full state is taken from registered occupancy. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Empty FIFO: a pop cannot occur, since vld=0.
- Pointers: FIFO read/write pointers wrap modulo OQ_DEPTH. Count uses $clog2(OQ_DEPTH)+1 bits.
- Parallelism: different inputs targeting different banks may all be accepted in the same cycle. Per-bank ordering from a single input is preserved.
- Reset asserted mid-operation: all queued requests are discarded immediately (async). The bank interfaces see sel_rd_vld drop without a handshake. Upstream must reissue.
- bank_oq_cnt[b] equals the registered FIFO occupancy of bank b.

Test Plan:
- Single request: input 3 sends cmd_addr[63:62]=2'b10, txnid=0x15, sel_rd_rdy=all 1.
  - rd_cmd_rdy[3]=1 in the same cycle.
  - Next cycle: sel_rd_vld=4'b0100 with txnid=0x15, opcode=READ, strb=0, db/rob ids=0.
- Round-robin contention: inputs 0, 2 and 5 all hold vld to bank 1 continuously, sel_rd_rdy[1]=1.
  - Grants occur in order 0, 2, 5, 0, 2, 5.
  - One push per cycle; bank 1 outputs one request every cycle.
- Backpressure: sel_rd_rdy[0]=0, with 4 requests from input 1 to bank 0 (OQ_DEPTH=2).
  - Two are accepted, then rd_cmd_rdy[1]=0 and bank_oq_cnt[0]=2.
  - Raise rdy: the remaining requests drain in FIFO order with no loss or duplication.
- Parallel banks: inputs 0..3 target banks 0..3 in the same cycle.
  - All four rd_cmd_rdy=1.
  - Next cycle sel_rd_vld=4'b1111, each bank carrying the correct txnid.
- Parametrisation: BANK_NUM=8, SEL_LSB=6, R_REQ_NUM=16; addr[8:6]=3'd7 routes to bank 7.
  - Random traffic with a scoreboard: per-input per-bank order is kept and every request is delivered exactly once.
- Mid-operation reset: pulse rst_n low with FIFOs holding 2, 1, 0 and 2 entries.
  - Immediately sel_rd_vld=0, bank_oq_cnt=0 and rd_cmd_rdy=0.
  - After release, the first grant goes to the lowest-indexed requester (RR pointers reset to 0).
